booth_radix4_multiplier: RTL and testbench

BOOTH_RADIX4_MULTIPLIER -- requirements
Module: booth_radix4_multiplier

---
 rtl/booth_radix4_multiplier.sv | 138 +++++++++++++
 tb/tb_booth_radix4_multiplier.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_multiplier.sv
// Radix-4 Booth sequential multiplier, signed or unsigned WIDTH x WIDTH -> 2*WIDTH.
// Latency: WIDTH/2+1 RUN cycles after the accepting edge; done pulses the cycle after.
// Backpressure: start is ignored while busy; a start in the done cycle chains back-to-back.
module booth_radix4_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  // Operands carry two extra bits so unsigned values stay positive under Booth recoding.
  localparam int E     = WIDTH + 2;
  localparam int N     = WIDTH / 2 + 1;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [E:0]         acc_q, acc_d;
  logic [E-1:0]       q_q, q_d;
  logic [E-1:0]       m_q, m_d;
  logic               qm1_q, qm1_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               accept;
  logic               last_iter;
  logic [2:0]         win;
  logic [E:0]         m_ext;
  logic [E:0]         term;
  logic [E:0]         sum;
  logic [E:0]         acc_sh;
  logic [E-1:0]       q_sh;
  logic               ext_m;
  logic               ext_q;

  assign product = prod_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Booth recoding of the current window and the add/shift step.
  always_comb begin
    accept    = start && (state_q != RUN);
    last_iter = (cnt_q == CNT_W'(N - 1));
    win       = {q_q[1:0], qm1_q};
    m_ext     = {m_q[E-1], m_q};
    case (win)
      3'b001, 3'b010: term = m_ext;
      3'b011:         term = m_ext << 1;
      3'b100:         term = -(m_ext << 1);
      3'b101, 3'b110: term = -m_ext;
      default:        term = '0;
    endcase
    sum    = acc_q + term;
    acc_sh = {{2{sum[E]}}, sum[E:2]};
    q_sh   = {sum[1:0], q_q[E-1:2]};
    ext_m  = signed_mode & multiplicand[WIDTH-1];
    ext_q  = signed_mode & multiplier[WIDTH-1];
  end

  // Datapath next-state: capture on accept, iterate in RUN, load product on the last step.
  always_comb begin
    acc_d  = acc_q;
    q_d    = q_q;
    m_d    = m_q;
    qm1_d  = qm1_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    if (accept) begin
      m_d   = {{2{ext_m}}, multiplicand};
      q_d   = {{2{ext_q}}, multiplier};
      acc_d = '0;
      qm1_d = 1'b0;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      acc_d = acc_sh;
      q_d   = q_sh;
      qm1_d = q_q[1];
      cnt_d = cnt_q + CNT_W'(1);
      if (last_iter) prod_d = {acc_sh[2*WIDTH-E-1:0], q_sh};
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      q_q    <= '0;
      m_q    <= '0;
      qm1_q  <= 1'b0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      acc_q  <= acc_d;
      q_q    <= q_d;
      m_q    <= m_d;
      qm1_q  <= qm1_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Bench for booth_radix4_multiplier: WIDTH=8 directed/random and WIDTH=16 random.
// Reference products come from plain integer multiplication.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_booth_radix4_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s8, sm8, bz8, dn8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        s16, sm16, bz16, dn16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int checks   = 0;
  int failures = 0;

  booth_radix4_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8),
    .product(p8), .busy(bz8), .done(dn8)
  );

  booth_radix4_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(s16), .signed_mode(sm16),
    .multiplicand(a16), .multiplier(b16),
    .product(p16), .busy(bz16), .done(dn16)
  );

  function automatic longint ref_prod(int w, bit sm, longint a, longint b);
    longint mask, x, y;
    mask = (longint'(1) << w) - 1;
    x = a & mask;
    y = b & mask;
    if (sm) begin
      if (((x >> (w - 1)) & 1) == 1) x = x - (longint'(1) << w);
      if (((y >> (w - 1)) & 1) == 1) y = y - (longint'(1) << w);
    end
    return (x * y) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // Runs one 8-bit operation, scrambling inputs after acceptance; lat counts edges after accept.
  task automatic op8(input bit sm, input logic [7:0] a, input logic [7:0] b,
                     output logic [15:0] p, output int lat, output int bcnt, output bit overlap);
    @(negedge clk);
    s8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(negedge clk);
    s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    lat = 0; bcnt = 0; overlap = 1'b0;
    while (!dn8 && lat < 40) begin
      if (bz8) bcnt++;
      @(negedge clk);
      lat++;
    end
    overlap = bz8 && dn8;
    p = p8;
  endtask

  task automatic op16(input bit sm, input logic [15:0] a, input logic [15:0] b,
                      output logic [31:0] p, output int lat);
    @(negedge clk);
    s16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
    @(negedge clk);
    s16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
    lat = 0;
    while (!dn16 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    p = p16;
  endtask

  task automatic test_reset();
    rst = 1'b1; s8 = 1'b1; s16 = 1'b1;
    sm8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sm16 = 1'b0; a16 = 16'h1234; b16 = 16'h5678;
    repeat (3) @(negedge clk);
    checks++;
    if (p8 !== 16'h0 || bz8 !== 1'b0 || dn8 !== 1'b0) begin
      failures++;
      $display("FAIL reset8 product=%h busy=%b done=%b expected 0000/0/0", p8, bz8, dn8);
    end
    checks++;
    if (p16 !== 32'h0 || bz16 !== 1'b0 || dn16 !== 1'b0) begin
      failures++;
      $display("FAIL reset16 product=%h busy=%b done=%b expected 0/0/0", p16, bz16, dn16);
    end
    rst = 1'b0; s8 = 1'b0; s16 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_corners();
    logic [15:0] p; int lat, bcnt; bit ov;
    op8(1'b1, 8'h80, 8'h80, p, lat, bcnt, ov);
    checks++;
    if (p !== 16'h4000) begin failures++; $display("FAIL s80x80 product=%h expected 4000", p); end
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL s80x80_latency got=%0d expected 5", lat); end
    checks++;
    if (bcnt !== 5 || ov) begin
      failures++; $display("FAIL s80x80_busy busy_cycles=%0d overlap=%b expected 5/0", bcnt, ov);
    end
    op8(1'b0, 8'hFF, 8'hFF, p, lat, bcnt, ov);
    checks++;
    if (p !== 16'hFE01) begin failures++; $display("FAIL uFFxFF product=%h expected fe01", p); end
    op8(1'b1, 8'hFF, 8'hFF, p, lat, bcnt, ov);
    checks++;
    if (p !== 16'h0001) begin failures++; $display("FAIL sFFxFF product=%h expected 0001", p); end
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    s8 = 1'b1; sm8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
    @(negedge clk);
    a8 = 8'h07; b8 = 8'h06;
    k = 0;
    while (!dn8 && k < 40) begin @(negedge clk); k++; end
    checks++;
    if (k !== 5 || p8 !== 16'hFFFF) begin
      failures++; $display("FAIL b2b_first latency=%0d product=%h expected 5/ffff", k, p8);
    end
    @(negedge clk);
    s8 = 1'b0;
    checks++;
    if (bz8 !== 1'b1 || dn8 !== 1'b0) begin
      failures++; $display("FAIL b2b_no_idle busy=%b done=%b expected 1/0", bz8, dn8);
    end
    k = 0;
    while (!dn8 && k < 40) begin @(negedge clk); k++; end
    checks++;
    if (k !== 5 || p8 !== 16'h002A) begin
      failures++; $display("FAIL b2b_second latency=%0d product=%h expected 5/002a", k, p8);
    end
  endtask

  task automatic test_busy_ignore();
    int k, extra; bit stable; logic [15:0] prev;
    @(negedge clk);
    s8 = 1'b1; sm8 = 1'b0; a8 = 8'd3; b8 = 8'd5;
    prev = p8;
    @(negedge clk);
    s8 = 1'b0;
    @(negedge clk);
    s8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
    @(negedge clk);
    s8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; sm8 = 1'b1;
    k = 2; stable = 1'b1;
    while (!dn8 && k < 40) begin
      if (p8 !== prev) stable = 1'b0;
      @(negedge clk);
      k++;
    end
    checks++;
    if (!stable) begin failures++; $display("FAIL product_changed_in_run expected %h held", prev); end
    checks++;
    if (k !== 5 || p8 !== 16'h000F) begin
      failures++; $display("FAIL busy_ignore latency=%0d product=%h expected 5/000f", k, p8);
    end
    extra = 0;
    repeat (8) begin @(negedge clk); if (dn8) extra++; end
    checks++;
    if (extra !== 0 || p8 !== 16'h000F) begin
      failures++; $display("FAIL busy_ignore_single_done extra_done=%0d product=%h expected 0/000f", extra, p8);
    end
  endtask

  task automatic test_reset_midrun();
    int extra; logic [15:0] p; int lat, bcnt; bit ov;
    @(negedge clk);
    s8 = 1'b1; sm8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F;
    @(negedge clk);
    s8 = 1'b0;
    @(negedge clk);
    rst = 1'b1; s8 = 1'b1;
    @(negedge clk);
    checks++;
    if (p8 !== 16'h0 || bz8 !== 1'b0 || dn8 !== 1'b0) begin
      failures++; $display("FAIL midrun_reset product=%h busy=%b done=%b expected 0000/0/0", p8, bz8, dn8);
    end
    rst = 1'b0; s8 = 1'b0;
    extra = 0;
    repeat (8) begin @(negedge clk); if (dn8 || bz8) extra++; end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL midrun_no_done activity_cycles=%0d expected 0", extra); end
    op8(1'b1, 8'h7F, 8'h7F, p, lat, bcnt, ov);
    checks++;
    if (p !== 16'h3F01 || lat !== 5) begin
      failures++; $display("FAIL after_reset product=%h latency=%0d expected 3f01/5", p, lat);
    end
  endtask

  task automatic test_random8();
    logic [15:0] p; logic [7:0] a, b; bit sm; int lat, bcnt; bit ov; longint exp;
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom); b = 8'($urandom); sm = 1'(i & 1);
      if (i < 8) begin a = (i & 2) ? 8'h80 : 8'hFF; b = (i & 4) ? 8'h80 : 8'h00; end
      op8(sm, a, b, p, lat, bcnt, ov);
      exp = ref_prod(8, sm, longint'(a), longint'(b));
      checks++;
      if (longint'(p) !== exp || lat !== 5 || bcnt !== 5 || ov) begin
        failures++;
        $display("FAIL rand8 sm=%0d a=%h b=%h product=%h latency=%0d busy=%0d expected %h/5/5", sm, a, b, p, lat, bcnt, exp);
      end
    end
  endtask

  task automatic test_random16();
    logic [31:0] p; logic [15:0] a, b; bit sm; int lat; longint exp;
    for (int i = 0; i < 4000; i++) begin
      a = 16'($urandom); b = 16'($urandom); sm = 1'(i & 1);
      if (i < 4) begin a = sm ? 16'h8000 : 16'hFFFF; b = a; end
      op16(sm, a, b, p, lat);
      exp = ref_prod(16, sm, longint'(a), longint'(b));
      checks++;
      if (longint'(p) !== exp) begin
        failures++; $display("FAIL rand16 sm=%0d a=%h b=%h product=%h expected %h", sm, a, b, p, exp);
      end
      checks++;
      if (lat !== 9) begin failures++; $display("FAIL rand16_latency got=%0d expected 9", lat); end
    end
  endtask

  initial begin
    rst = 1'b1;
    s8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    s16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_corners();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midrun();
    test_random8();
    test_random16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
